bot_port_master: RTL and testbench
==================================

// Module: bot_port_master
// PURPOSE
//  Hardware initiator for the 8-bit port bus (port_id/in_port/out_port, strobes, interrupt/ack);
//  drop-in replacement for the soft CPU in front of nexys4_bot_if. On each bot-update interrupt it
//  reads LocX/LocY/Sensors/BotInfo, computes a line-follow motor command and writes MotCtl and LEDs.
//  A watchdog forces a stop if interrupts cease.
// PARAMETERS
//  P_LOCX     8'h0A     input port: bot X location
//  P_LOCY     8'h0B     input port: bot Y location
//  P_SENSORS  8'h0C     input port: sensors; [2:0] = {L,C,R} line detect, 1 = on line
//  P_BOTINFO  8'h0D     input port: bot info; echoed to LEDs
//  P_MOTCTL   8'h09     output port: motor control
//  P_LEDS     8'h02     output port: LED[7:0]
//  MOT_FWD    8'h33     cmd: forward      MOT_LEFT 8'h03 turn left   MOT_RIGHT 8'h30 turn right
//  MOT_STOP   8'h00     cmd: stop
//  WDOG_CYC   2_000_000 cycles without interrupt before forced stop (>=32)
// PORTS
//  clk            in   1  system clock, 100 MHz
//  rst            in   1  synchronous reset, active high
//  port_id        out  8  port address
//  out_port       out  8  write data
//  in_port        in   8  read data, registered by responder (valid 1 cycle after port_id)
//  read_strobe    out  1  read qualifier, 1-cycle pulse
//  write_strobe   out  1  write qualifier, 1-cycle pulse
//  k_write_strobe out  1  constant-write strobe; tied 0
//  interrupt      in   1  level request from responder (bot registers updated)
//  interrupt_ack  out  1  1-cycle acknowledge; responder clears interrupt
//  busy           out  1  high while a transaction sequence is in progress
// BEHAVIOUR
//  Reset: port_id=0, out_port=0, all strobes=0, interrupt_ack=0, busy=0, last_turn=LEFT, wdog=0, state IDLE.
//  Read bus cycle (2 clk): RSET drives port_id; RSTB holds port_id, read_strobe=1, captures in_port at end.
//  Write bus cycle (2 clk): WSET drives port_id+out_port; WSTB holds both, write_strobe=1.
//  port_id/out_port hold last value between cycles; never change while a strobe is high.
//  States: IDLE -> ACK -> RD LOCX,LOCY,SENSORS,BOTINFO (RSET/RSTB each) -> DECIDE -> WR MOTCTL -> WR LEDS -> IDLE.
//  IDLE: interrupt=1 -> ACK (interrupt_ack=1 one cycle, busy=1). Interrupt->ack latency 1 clk.
//  Full sequence 14 clk ACK..last WSTB; busy falls on return to IDLE. Interrupt during sequence is
//  not acked until IDLE; still-high level on IDLE entry starts a new sequence next cycle.
//  DECIDE on sensors[2:0]: 010,111 -> FWD; 100,110 -> LEFT, last_turn=LEFT; 001,011 -> RIGHT,
//  last_turn=RIGHT; 101 -> FWD; 000 -> repeat last_turn cmd (search).
//  LEDS write data = botinfo captured this sequence.
//  Watchdog: counts clk in IDLE, cleared on ACK; at WDOG_CYC-1 (saturating) performs one WR MOTCTL=MOT_STOP
//  (busy=1, no ack), then IDLE with counter cleared. Interrupt arriving same cycle as timeout: interrupt wins.
//  rst mid-sequence: all strobes drop same edge; partial reads discarded; no write issued.
// CONFIGURATION
//  BOT_PORT_MASTER_DIGITS_EN defined: after WR LEDS add WR 8'h13 = LocX[3:0] and WR 8'h14 = LocX[7:4]
//  (digit ports, 5-bit digit codes zero-extended); sequence 18 clk. Undefined: no digit writes, 14 clk.
// TESTING
//  Reset then idle 100 clk -> no strobes, port_id=0, busy=0, interrupt_ack=0.
//  interrupt=1, responder model sensors=3'b010, botinfo=8'hA5 -> ack 1 clk later; reads 0A,0B,0C,0D
//    in order; writes (09,33) then (02,A5); each strobe exactly 1 clk wide.
//  Sensors 110 -> MotCtl 03; next interrupt with sensors 000 -> MotCtl 03 (search repeats left).
//  Set WDOG_CYC=64, no interrupts -> single write (09,00) at cycle 64 after IDLE entry, repeats every ~64+2.
//  Interrupt held high through sequence -> second ACK on cycle after IDLE re-entry; rst asserted on
//    RSTB of SENSORS read -> next edge all strobes 0, state IDLE, no MotCtl write.
//  With BOT_PORT_MASTER_DIGITS_EN, LocX=8'h5C -> extra writes (13,0C),(14,05); sequence 18 clk.

Source files
------------

// File: rtl/bot_port_master.sv
// Port-bus initiator that services bot-update interrupts with a line-follow controller and watchdog stop.
// Optional digit-port writes of LocX are enabled by defining BOT_PORT_MASTER_DIGITS_EN.
module bot_port_master #(
   parameter int unsigned WDOG_CYC  = 2_000_000,
   parameter logic [7:0]  P_LOCX    = 8'h0A,
   parameter logic [7:0]  P_LOCY    = 8'h0B,
   parameter logic [7:0]  P_SENSORS = 8'h0C,
   parameter logic [7:0]  P_BOTINFO = 8'h0D,
   parameter logic [7:0]  P_MOTCTL  = 8'h09,
   parameter logic [7:0]  P_LEDS    = 8'h02,
   parameter logic [7:0]  MOT_FWD   = 8'h33,
   parameter logic [7:0]  MOT_LEFT  = 8'h03,
   parameter logic [7:0]  MOT_RIGHT = 8'h30,
   parameter logic [7:0]  MOT_STOP  = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] port_id,
   output logic [7:0] out_port,
   input  logic [7:0] in_port,
   output logic       read_strobe,
   output logic       write_strobe,
   output logic       k_write_strobe,
   input  logic       interrupt,
   output logic       interrupt_ack,
   output logic       busy
);

   localparam int unsigned WD_W = $clog2(WDOG_CYC);
   localparam logic [7:0]  P_DIG_LO = 8'h13;
   localparam logic [7:0]  P_DIG_HI = 8'h14;
   localparam logic        TURN_LEFT  = 1'b0;
   localparam logic        TURN_RIGHT = 1'b1;
`ifdef BOT_PORT_MASTER_DIGITS_EN
   localparam logic [1:0]  WR_LAST = 2'd3;
`else
   localparam logic [1:0]  WR_LAST = 2'd1;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_ACK, S_RSET, S_RSTB, S_DECIDE, S_WSET, S_WSTB
   } state_t;

   state_t          state, state_d;
   logic [1:0]      rd_idx, rd_idx_d;
   logic [1:0]      wr_idx, wr_idx_d;
   logic            wd_mode, wd_mode_d;
   logic [7:0]      port_id_d, out_port_d;
   logic [WD_W-1:0] wdog;
   logic            last_turn;
   logic [2:0]      sensors;
   logic [7:0]      botinfo;
   logic [7:0]      mot_cmd_c;
`ifdef BOT_PORT_MASTER_DIGITS_EN
   logic [7:0]      locx;
`endif

   assign k_write_strobe = 1'b0;

   function automatic logic [7:0] rd_port(input logic [1:0] idx);
      case (idx)
         2'd0:    rd_port = P_LOCX;
         2'd1:    rd_port = P_LOCY;
         2'd2:    rd_port = P_SENSORS;
         default: rd_port = P_BOTINFO;
      endcase
   endfunction

   // Line-follow decision; all-off repeats the last turn to search for the line
   always_comb begin
      mot_cmd_c = MOT_FWD;
      case (sensors)
         3'b100, 3'b110: mot_cmd_c = MOT_LEFT;
         3'b001, 3'b011: mot_cmd_c = MOT_RIGHT;
         3'b000:         mot_cmd_c = (last_turn == TURN_LEFT) ? MOT_LEFT : MOT_RIGHT;
         default:        mot_cmd_c = MOT_FWD;
      endcase
   end

   always_comb begin
      state_d    = state;
      rd_idx_d   = rd_idx;
      wr_idx_d   = wr_idx;
      wd_mode_d  = wd_mode;
      port_id_d  = port_id;
      out_port_d = out_port;
      unique case (state)
         S_IDLE: begin
            if (interrupt) begin
               state_d = S_ACK;
            end else if (wdog == WD_W'(WDOG_CYC - 1)) begin
               state_d    = S_WSET;
               wd_mode_d  = 1'b1;
               wr_idx_d   = 2'd0;
               port_id_d  = P_MOTCTL;
               out_port_d = MOT_STOP;
            end
         end
         S_ACK: begin
            state_d   = S_RSET;
            rd_idx_d  = 2'd0;
            wd_mode_d = 1'b0;
            port_id_d = P_LOCX;
         end
         S_RSET: state_d = S_RSTB;
         S_RSTB: begin
            if (rd_idx == 2'd3) begin
               state_d = S_DECIDE;
            end else begin
               state_d   = S_RSET;
               rd_idx_d  = rd_idx + 2'd1;
               port_id_d = rd_port(rd_idx + 2'd1);
            end
         end
         S_DECIDE: begin
            state_d    = S_WSET;
            wr_idx_d   = 2'd0;
            port_id_d  = P_MOTCTL;
            out_port_d = mot_cmd_c;
         end
         S_WSET: state_d = S_WSTB;
         S_WSTB: begin
            if (wd_mode || wr_idx == WR_LAST) begin
               state_d = S_IDLE;
            end else begin
               state_d  = S_WSET;
               wr_idx_d = wr_idx + 2'd1;
               case (wr_idx + 2'd1)
`ifdef BOT_PORT_MASTER_DIGITS_EN
                  2'd2: begin
                     port_id_d  = P_DIG_LO;
                     out_port_d = {4'h0, locx[3:0]};
                  end
                  2'd3: begin
                     port_id_d  = P_DIG_HI;
                     out_port_d = {4'h0, locx[7:4]};
                  end
`endif
                  default: begin
                     port_id_d  = P_LEDS;
                     out_port_d = botinfo;
                  end
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered bus outputs, derived from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         rd_idx        <= 2'd0;
         wr_idx        <= 2'd0;
         wd_mode       <= 1'b0;
         port_id       <= 8'h00;
         out_port      <= 8'h00;
         read_strobe   <= 1'b0;
         write_strobe  <= 1'b0;
         interrupt_ack <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_d;
         rd_idx        <= rd_idx_d;
         wr_idx        <= wr_idx_d;
         wd_mode       <= wd_mode_d;
         port_id       <= port_id_d;
         out_port      <= out_port_d;
         read_strobe   <= (state_d == S_RSTB);
         write_strobe  <= (state_d == S_WSTB);
         interrupt_ack <= (state_d == S_ACK);
         busy          <= (state_d != S_IDLE);
      end
   end

   // Read capture, turn memory and idle watchdog
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog      <= '0;
         last_turn <= TURN_LEFT;
         sensors   <= 3'b000;
         botinfo   <= 8'h00;
`ifdef BOT_PORT_MASTER_DIGITS_EN
         locx      <= 8'h00;
`endif
      end else begin
         if (state == S_IDLE && state_d == S_IDLE && wdog != WD_W'(WDOG_CYC - 1))
            wdog <= wdog + WD_W'(1);
         else
            wdog <= '0;
         if (state == S_RSTB) begin
            case (rd_idx)
`ifdef BOT_PORT_MASTER_DIGITS_EN
               2'd0:    locx    <= in_port;
`endif
               2'd2:    sensors <= in_port[2:0];
               2'd3:    botinfo <= in_port;
               default: ;
            endcase
         end
         if (state == S_DECIDE) begin
            case (sensors)
               3'b100, 3'b110: last_turn <= TURN_LEFT;
               3'b001, 3'b011: last_turn <= TURN_RIGHT;
               default:        ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bot_port_master.sv
// Directed bench for bot_port_master: bus sequences, line-follow decisions, watchdog and reset abort.
module tb_bot_port_master;

`ifdef BOT_PORT_MASTER_DIGITS_EN
   localparam int SEQ_LEN = 18;
   localparam int N_TR    = 8;
`else
   localparam int SEQ_LEN = 14;
   localparam int N_TR    = 6;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] port_id, out_port, in_port;
   logic       read_strobe, write_strobe, k_write_strobe;
   logic       interrupt, interrupt_ack, busy;

   logic [2:0] sens_m;
   logic [7:0] botinfo_m, locx_m;
   logic [16:0] trq[$];
   int n_cmp = 0;
   int n_fail = 0;

   bot_port_master #(.WDOG_CYC(64)) dut (
      .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port), .in_port(in_port),
      .read_strobe(read_strobe), .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
      .interrupt(interrupt), .interrupt_ack(interrupt_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   // Responder: registered read data, one cycle behind port_id
   always @(posedge clk) begin
      case (port_id)
         8'h0A:   in_port <= locx_m;
         8'h0B:   in_port <= 8'h77;
         8'h0C:   in_port <= {5'b10101, sens_m};
         8'h0D:   in_port <= botinfo_m;
         default: in_port <= 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (read_strobe)  trq.push_back({1'b0, port_id, 8'h00});
      if (write_strobe) trq.push_back({1'b1, port_id, out_port});
   endtask

   task automatic run_seq(input string tag, input logic [2:0] s, input logic [7:0] bi,
                          input logic [7:0] lx, input logic [7:0] mot, input bit hold);
      logic [16:0] exp_q[$];
      int busy_cyc, ack_cyc;
      sens_m = s; botinfo_m = bi; locx_m = lx;
      trq.delete();
      interrupt = 1'b1;
      tick();
      check({tag, "_ack"}, 32'(interrupt_ack), 32'd1);
      if (!hold) interrupt = 1'b0;
      busy_cyc = busy ? 1 : 0;
      ack_cyc = 1;
      for (int i = 0; i < 40 && busy; i++) begin
         tick();
         if (busy) busy_cyc++;
         if (interrupt_ack) ack_cyc++;
      end
      check({tag, "_len"}, 32'(busy_cyc), 32'(SEQ_LEN));
      check({tag, "_ackw"}, 32'(ack_cyc), 32'd1);
      exp_q = '{{1'b0, 8'h0A, 8'h00}, {1'b0, 8'h0B, 8'h00}, {1'b0, 8'h0C, 8'h00},
                {1'b0, 8'h0D, 8'h00}, {1'b1, 8'h09, mot}, {1'b1, 8'h02, bi}};
`ifdef BOT_PORT_MASTER_DIGITS_EN
      exp_q.push_back({1'b1, 8'h13, 4'h0, lx[3:0]});
      exp_q.push_back({1'b1, 8'h14, 4'h0, lx[7:4]});
`endif
      check({tag, "_ntr"}, 32'(trq.size()), 32'(N_TR));
      for (int i = 0; i < N_TR && i < trq.size(); i++)
         check($sformatf("%s_tr%0d", tag, i), 32'(trq[i]), 32'(exp_q[i]));
   endtask

   initial begin
      int first_w, second_w, acks, idx;
      logic [7:0] wd_port, wd_data;
      bit found;
      rst = 1'b1; interrupt = 1'b0;
      sens_m = 3'b000; botinfo_m = 8'h00; locx_m = 8'h00;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_port_id", 32'(port_id), 32'h0);
      check("rst_out_port", 32'(out_port), 32'h0);
      check("rst_strobes", 32'({read_strobe, write_strobe, k_write_strobe}), 32'h0);
      check("rst_ack_busy", 32'({interrupt_ack, busy}), 32'h0);

      // Quiet period shorter than the watchdog: nothing on the bus
      trq.delete();
      acks = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (busy || interrupt_ack || port_id != 8'h00) acks++;
      end
      check("idle_quiet", 32'(acks), 32'd0);
      check("idle_ntr", 32'(trq.size()), 32'd0);

      run_seq("fwd",    3'b010, 8'hA5, 8'h5C, 8'h33, 1'b0);
      run_seq("left",   3'b110, 8'h3C, 8'h5C, 8'h03, 1'b0);
      run_seq("srchL",  3'b000, 8'h11, 8'hE7, 8'h03, 1'b0);
      run_seq("right",  3'b011, 8'h22, 8'h5C, 8'h30, 1'b0);
      run_seq("srchR",  3'b000, 8'h33, 8'h5C, 8'h30, 1'b0);
      run_seq("both",   3'b101, 8'h44, 8'h5C, 8'h33, 1'b0);
      run_seq("hold",   3'b111, 8'h55, 8'h5C, 8'h33, 1'b1);

      // Level still high on IDLE entry: acked on the very next cycle
      tick();
      check("hold_reack", 32'(interrupt_ack), 32'd1);
      interrupt = 1'b0;
      for (int i = 0; i < 40 && busy; i++) tick();
      check("hold_drain", 32'(busy), 32'd0);

      // Watchdog: idx 0 is IDLE entry, stop write strobe expected at idx 65 then every 66
      first_w = -1; second_w = -1; acks = 0; idx = 0;
      wd_port = 8'hFF; wd_data = 8'hFF;
      for (int i = 0; i < 140; i++) begin
         tick();
         idx++;
         if (interrupt_ack) acks++;
         if (write_strobe && first_w < 0) begin
            first_w = idx; wd_port = port_id; wd_data = out_port;
         end else if (write_strobe && second_w < 0) begin
            second_w = idx;
         end
      end
      check("wd_first", 32'(first_w), 32'd65);
      check("wd_port", 32'(wd_port), 32'h09);
      check("wd_data", 32'(wd_data), 32'h00);
      check("wd_second", 32'(second_w), 32'd131);
      check("wd_noack", 32'(acks), 32'd0);

      // Abort during the SENSORS read strobe
      sens_m = 3'b100; botinfo_m = 8'h66; locx_m = 8'h12;
      interrupt = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (interrupt_ack) interrupt = 1'b0;
         if (read_strobe && port_id == 8'h0C) found = 1'b1;
      end
      check("abort_found", 32'(found), 32'd1);
      rst = 1'b1;
      tick();
      check("abort_strobes", 32'({read_strobe, write_strobe, interrupt_ack}), 32'h0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_port", 32'(port_id), 32'h0);
      rst = 1'b0;
      trq.delete();
      for (int i = 0; i < 20; i++) tick();
      check("abort_nowrite", 32'(trq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
